// File: rtl/dct2d_block_sequencer_if.sv
// dct2d_block_sequencer_if: control, load, 1-D pipeline and output signals of the 2-D DCT block sequencer
interface dct2d_block_sequencer_if #(parameter int DATA_W = 32);
  logic start;
  logic in_wr;
  logic [DATA_W-1:0] in_data;
  logic in_ready;
  logic [8*DATA_W-1:0] dct_i;
  logic dct_en;
  logic [8*DATA_W-1:0] dct_m;
  logic dct_valid;
  logic [DATA_W-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic busy;
  logic done;
  logic err;
  modport slave (
    input start, in_wr, in_data, dct_m, dct_valid, out_ready,
    output in_ready, dct_i, dct_en, out_data, out_valid, busy, done, err
  );
  modport master (
    output start, in_wr, in_data, dct_m, dct_valid, out_ready,
    input in_ready, dct_i, dct_en, out_data, out_valid, busy, done, err
  );
endinterface

// File: rtl/dct2d_block_sequencer.sv
// dct2d_block_sequencer: runs an 8x8 block through a shared 1-D DCT pipe, rows then columns, with transposed stores
module dct2d_block_sequencer #(
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic reset,
  dct2d_block_sequencer_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT + 2);
  typedef enum logic [2:0] {IDLE, LOAD, ROW_ISSUE, ROW_DRAIN, COL_ISSUE, COL_DRAIN, OUT} state_t;
  state_t state_q, state_d;
  logic [5:0] wcnt_q, wcnt_d;
  logic [3:0] icnt_q, icnt_d, rcnt_q, rcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic err_q, err_d, done_q, done_d;
  logic [8*DATA_W-1:0] dct_i_q, dct_i_d, vec;
  logic [DATA_W-1:0] a_mem [64];
  logic [DATA_W-1:0] b_mem [64];
  logic issue, col, capture;
  assign issue = state_q == ROW_ISSUE || state_q == COL_ISSUE;
  assign col = state_q == COL_ISSUE || state_q == COL_DRAIN;
  assign capture = (issue || state_q == ROW_DRAIN || state_q == COL_DRAIN) && bus.dct_valid && !rcnt_q[3];
  // Row icnt of the source buffer: A in the row pass, B in the column pass
  always_comb begin
    vec = '0;
    for (int j = 0; j < 8; j++)
      vec[j*DATA_W +: DATA_W] = col ? b_mem[{icnt_q[2:0], 3'(j)}] : a_mem[{icnt_q[2:0], 3'(j)}];
  end
  // Next-state, counter and flag logic
  always_comb begin
    state_d = state_q;
    wcnt_d = wcnt_q;
    icnt_d = icnt_q;
    rcnt_d = rcnt_q;
    tcnt_d = tcnt_q;
    err_d = err_q;
    done_d = 1'b0;
    dct_i_d = issue ? vec : dct_i_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = LOAD;
          err_d = 1'b0;
          wcnt_d = '0;
          icnt_d = '0;
          rcnt_d = '0;
          tcnt_d = '0;
        end
      end
      LOAD: begin
        wcnt_d = bus.in_wr ? wcnt_q + 6'd1 : wcnt_q;
        state_d = (bus.in_wr && wcnt_q == 6'd63) ? ROW_ISSUE : LOAD;
      end
      OUT: begin
        wcnt_d = bus.out_ready ? wcnt_q + 6'd1 : wcnt_q;
        if (bus.out_ready && wcnt_q == 6'd63) begin
          state_d = IDLE;
          done_d = 1'b1;
        end
      end
      default: begin
        icnt_d = issue ? icnt_q + 4'd1 : icnt_q;
        rcnt_d = capture ? rcnt_q + 4'd1 : rcnt_q;
        tcnt_d = (issue || bus.dct_valid) ? '0 : (rcnt_q < icnt_q) ? tcnt_q + 1'b1 : tcnt_q;
        if (issue && icnt_q == 4'd7)
          state_d = col ? COL_DRAIN : ROW_DRAIN;
        if (rcnt_d == 4'd8 && icnt_d == 4'd8) begin
          state_d = col ? OUT : COL_ISSUE;
          icnt_d = '0;
          rcnt_d = '0;
          tcnt_d = '0;
          wcnt_d = '0;
        end else if (tcnt_d > TW'(TIMEOUT)) begin
          state_d = IDLE;
          err_d = 1'b1;
        end
      end
    endcase
  end
  // State and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wcnt_q <= '0;
      icnt_q <= '0;
      rcnt_q <= '0;
      tcnt_q <= '0;
      err_q <= 1'b0;
      done_q <= 1'b0;
      dct_i_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q <= wcnt_d;
      icnt_q <= icnt_d;
      rcnt_q <= rcnt_d;
      tcnt_q <= tcnt_d;
      err_q <= err_d;
      done_q <= done_d;
      dct_i_q <= dct_i_d;
    end
  end
  // Sample buffers: input load, and result vectors stored as columns (transpose)
  always_ff @(posedge clk) begin
    if (state_q == LOAD && bus.in_wr)
      a_mem[wcnt_q] <= bus.in_data;
    if (capture)
      for (int j = 0; j < 8; j++)
        if (col)
          a_mem[{3'(j), rcnt_q[2:0]}] <= bus.dct_m[j*DATA_W +: DATA_W];
        else
          b_mem[{3'(j), rcnt_q[2:0]}] <= bus.dct_m[j*DATA_W +: DATA_W];
  end
  assign bus.in_ready = state_q == LOAD;
  assign bus.dct_en = issue;
  assign bus.dct_i = dct_i_d;
  assign bus.out_valid = state_q == OUT;
  assign bus.out_data = state_q == OUT ? a_mem[wcnt_q] : '0;
  assign bus.busy = state_q != IDLE;
  assign bus.done = done_q;
  assign bus.err = err_q;
endmodule

// File: tb/tb_dct2d_block_sequencer.sv
// tb_dct2d_block_sequencer: random blocks through a modelled 1-D pipe, scoreboarded against a matrix model
module tb_dct2d_block_sequencer;
  localparam int DW = 32;
  localparam int TO = 255;
  logic clk = 1'b0;
  logic reset = 1'b0;
  dct2d_block_sequencer_if #(.DATA_W(DW)) bus ();
  dct2d_block_sequencer #(.DATA_W(DW), .TIMEOUT(TO)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt = 0;
  logic [DW-1:0] exp_q [$];
  int cyc = 0;
  int lat = 3;
  int rot = 0;
  int limit = 0;
  int nret = 0;
  int last_evt = 0;
  int en_cnt = 0;
  int ph = 0;
  logic [DW-1:0] addc = '0;
  bit bp = 1'b0;
  bit ident = 1'b0;
  bit hen [32];
  logic [8*DW-1:0] hv [32];
  logic [DW-1:0] x [64];
  bit hold = 1'b0;
  logic [DW-1:0] hold_data = '0;

  task automatic check(input string name, input logic [8*DW-1:0] act, input logic [8*DW-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // The modelled pipe: rotate elements by rot and add addc to each word
  function automatic logic [8*DW-1:0] pipe_f(input logic [8*DW-1:0] v);
    logic [8*DW-1:0] r;
    for (int j = 0; j < 8; j++) r[j*DW +: DW] = v[((j + rot) % 8)*DW +: DW] + addc;
    return r;
  endfunction

  // Two passes of: apply the pipe to every row, then store the results as columns
  task automatic push_expected();
    logic [DW-1:0] b [64];
    logic [DW-1:0] a [64];
    for (int r = 0; r < 8; r++)
      for (int j = 0; j < 8; j++) b[8*j + r] = x[8*r + (j + rot) % 8] + addc;
    for (int r = 0; r < 8; r++)
      for (int j = 0; j < 8; j++) a[8*j + r] = b[8*r + (j + rot) % 8] + addc;
    for (int k = 0; k < 64; k++) exp_q.push_back(a[k]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_dct_en"}, bus.dct_en, 0);
    check({tag, "_dct_i"}, bus.dct_i, 0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_data"}, bus.out_data, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_err"}, bus.err, 0);
  endtask

  task automatic start_and_load(input int n);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("in_ready_after_start", bus.in_ready, 1);
    check("err_after_start", bus.err, 0);
    check("done_one_cycle", bus.done, 0);
    for (int k = 0; k < n; k++) begin
      while ($urandom % 4 == 0) begin
        bus.in_wr = 1'b0;
        bus.start = 1'($urandom % 2);
        @(posedge clk); #1;
      end
      bus.in_wr = 1'b1;
      bus.in_data = x[k];
      bus.start = 1'($urandom % 2);
      @(posedge clk); #1;
    end
    bus.in_wr = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic run_block(input int l, input int r, input logic [DW-1:0] c, input bit b, input bit id);
    int t;
    lat = l; rot = r; addc = c; bp = b; ident = id; limit = 0; nret = 0; en_cnt = 0;
    for (int k = 0; k < 64; k++) x[k] = id ? DW'(k) : DW'($urandom);
    push_expected();
    start_and_load(64);
    for (t = 0; t < 3000 && !bus.done; t++) begin
      @(posedge clk); #1;
    end
    if (!bus.done) begin
      chk_cnt++;
      $display("FAIL done_wait: got no done within %0d cycles, required a done pulse", t);
    end
    check("scoreboard_drained", exp_q.size(), 0);
    check("dct_en_cycles", en_cnt, 16);
  endtask

  initial forever @(posedge clk) cyc++;

  // Pipe with latency lat; optional cap on returned vectors per block
  initial begin
    bus.dct_valid = 1'b0;
    bus.dct_m = '0;
    forever @(negedge clk) begin
      hen[cyc % 32] = bus.dct_en;
      hv[cyc % 32] = pipe_f(bus.dct_i);
      if (cyc >= lat && hen[(cyc - lat) % 32] && (limit == 0 || nret < limit)) begin
        bus.dct_valid = 1'b1;
        bus.dct_m = hv[(cyc - lat) % 32];
        nret++;
      end else bus.dct_valid = 1'b0;
      if (bus.dct_en || bus.dct_valid) last_evt = cyc;
      if (bus.dct_en && ident && en_cnt == 2) begin
        check("row2_elem0", bus.dct_i[DW-1:0], 16);
        check("row2_elem7", bus.dct_i[8*DW-1:7*DW], 23);
      end
      en_cnt += int'(bus.dct_en);
    end
  end

  // Scoreboard monitor: pops on each output handshake, and checks held data under backpressure
  initial forever @(negedge clk) begin
    if (hold) check("out_hold", {bus.out_valid, bus.out_data}, {1'b1, hold_data});
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL out_extra: got %0h with nothing expected", bus.out_data);
      end else check("out_data", bus.out_data, exp_q.pop_front());
    end
    hold = bus.out_valid && !bus.out_ready;
    hold_data = bus.out_data;
  end

  // Downstream ready: always 1, or the 1,0,0,1 pattern under backpressure
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.out_ready = !bp || (ph % 4 == 0) || (ph % 4 == 3);
      ph++;
    end
  end

  initial begin
    int t;
    bit saw_done;
    bus.start = 1'b0;
    bus.in_wr = 1'b0;
    bus.in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    run_block(3, 0, '0, 1'b0, 1'b1);
    run_block(1, 0, '0, 1'b0, 1'b1);
    run_block(12, 0, '0, 1'b0, 1'b1);
    run_block(3, 0, '0, 1'b1, 1'b1);
    run_block(3, 1 + $urandom % 7, DW'($urandom), 1'b1, 1'b0);
    run_block(1 + $urandom % 15, 1 + $urandom % 7, DW'($urandom), 1'b0, 1'b0);
    // Pipe returns only five row vectors: the block must abort on timeout
    lat = 3; rot = 0; addc = '0; bp = 1'b0; ident = 1'b0; limit = 5; nret = 0;
    for (int k = 0; k < 64; k++) x[k] = DW'($urandom);
    start_and_load(64);
    saw_done = 1'b0;
    for (t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
      if (!bus.busy) break;
    end
    check("timeout_busy", bus.busy, 0);
    check("timeout_err", bus.err, 1);
    check("timeout_done", bus.done, 0);
    check("timeout_no_done_pulse", saw_done, 0);
    check("timeout_idle_cycles", cyc - last_evt, TO + 2);
    repeat (3) @(posedge clk);
    #1;
    check("err_sticky", bus.err, 1);
    run_block(5, 2, DW'($urandom), 1'b0, 1'b0);
    // Reset in the middle of LOAD; nothing from the aborted block may appear
    lat = 3; rot = 0; addc = '0; limit = 0;
    for (int k = 0; k < 64; k++) x[k] = DW'($urandom);
    start_and_load(30);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("post_reset_busy", bus.busy, 0);
    run_block(4, 3, DW'($urandom), 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
